// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the backing-memory port arbiter and its neighbours.
package mem_port_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StInstBeat = 2'd1,
    StDataXfer = 2'd2
  } arb_state_e;

  // Port owner encoding, used for round-robin fairness
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Defaults shared with l1_cache
  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_LINE_WORDS = 4;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Per-beat ack timeout counter. Counts enabled cycles spent waiting for an ack;
// expired is asserted on the wait cycle whose edge would bring the count to
// TIMEOUT_CYC-1.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] count_q;

  // Wait-cycle counter; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clk_en) begin
      if (clr) begin
        count_q <= '0;
      end else if (inc) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign expired = inc && (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single backing-memory port between icache line refills and
// data loads/stores. Round-robin on contention, back-to-back line beats,
// per-beat ack timeout. All outputs registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic                          i_gnt,
  output logic                          i_rvalid,
  output logic [DATA_W-1:0]             i_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] i_beat,
  output logic                          i_done,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic                          d_gnt,
  output logic                          d_rvalid,
  output logic [DATA_W-1:0]             d_rdata,
  output logic                          d_done,
  output logic                          err,
  output logic                          m_req,
  output logic                          m_we,
  output logic [ADDR_W-1:0]             m_addr,
  output logic [DATA_W-1:0]             m_wdata,
  input  logic                          m_ack,
  input  logic [DATA_W-1:0]             m_rdata
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  arb_state_e        state_q;
  logic              last_owner_q;
  logic [BEAT_W-1:0] beat_q;

  logic wd_clr;
  logic wd_inc;
  logic wd_expired;

  // Line offset bits of the refill address are replaced by the beat counter
  logic unused_i_addr_bits;
  assign unused_i_addr_bits = ^i_addr[BEAT_W-1:0];

  // Waiting = request outstanding with no ack this cycle; anything else restarts
  assign wd_inc = m_req && !m_ack;
  assign wd_clr = !wd_inc || wd_expired;

  mem_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expired(wd_expired)
  );

  // Sequencing FSM with registered outputs; frozen when clk_en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_owner_q <= OWN_INST;
      beat_q       <= '0;
      i_gnt        <= 1'b0;
      i_rvalid     <= 1'b0;
      i_rdata      <= '0;
      i_beat       <= '0;
      i_done       <= 1'b0;
      d_gnt        <= 1'b0;
      d_rvalid     <= 1'b0;
      d_rdata      <= '0;
      d_done       <= 1'b0;
      err          <= 1'b0;
      m_req        <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
    end else if (clk_en) begin
      i_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_rvalid <= 1'b0;
      d_done   <= 1'b0;
      err      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Data wins if alone or if instruction side owned the port last
          if (d_req && (!i_req || last_owner_q == OWN_INST)) begin
            state_q      <= StDataXfer;
            last_owner_q <= OWN_DATA;
            d_gnt        <= 1'b1;
            m_req        <= 1'b1;
            m_we         <= d_we;
            m_addr       <= d_addr;
            m_wdata      <= d_wdata;
          end else if (i_req) begin
            state_q      <= StInstBeat;
            last_owner_q <= OWN_INST;
            beat_q       <= '0;
            i_gnt        <= 1'b1;
            m_req        <= 1'b1;
            m_we         <= 1'b0;
            m_addr       <= {i_addr[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
            m_wdata      <= '0;
          end
        end
        StInstBeat: begin
          if (m_ack) begin
            i_rvalid <= 1'b1;
            i_rdata  <= m_rdata;
            i_beat   <= beat_q;
            if (beat_q == LAST_BEAT) begin
              i_done  <= 1'b1;
              i_gnt   <= 1'b0;
              m_req   <= 1'b0;
              beat_q  <= '0;
              state_q <= StIdle;
            end else begin
              // Offset bits only; never carries into the line address
              beat_q               <= beat_q + BEAT_W'(1);
              m_addr[BEAT_W-1:0]   <= beat_q + BEAT_W'(1);
            end
          end else if (wd_expired) begin
            // Abort drops the rest of the line
            i_done  <= 1'b1;
            err     <= 1'b1;
            i_gnt   <= 1'b0;
            m_req   <= 1'b0;
            beat_q  <= '0;
            state_q <= StIdle;
          end
        end
        StDataXfer: begin
          if (m_ack) begin
            d_done  <= 1'b1;
            d_gnt   <= 1'b0;
            m_req   <= 1'b0;
            state_q <= StIdle;
            if (!m_we) begin
              d_rvalid <= 1'b1;
              d_rdata  <= m_rdata;
            end
          end else if (wd_expired) begin
            d_done  <= 1'b1;
            err     <= 1'b1;
            d_gnt   <= 1'b0;
            m_req   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          i_gnt   <= 1'b0;
          d_gnt   <= 1'b0;
          m_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
